sfifo_rd_packer: RTL and testbench
==================================

Name: sfifo_rd_packer

Overview:
- Drains the synchronous FIFO through its read port (rinc / rempty / rdata) and packs RATIO consecutive WIDTH-bit words into one wide word.
- Presents the packed word on a valid/ready master stream; downstream is the wide datapath.
- A flush pulse emits a partial word with a lane-keep mask.
- Sits directly downstream of the FIFO, on the same clock.

Parameters:
WIDTH, 8, FIFO word width (bits)
RATIO, 4, FIFO words per packed output word; power of two, >=2
LW (derived), $clog2(RATIO)+1, lane counter width

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
rempty  input  1  FIFO empty flag (registered in FIFO, lags pointer by one cycle)
rdata  input  WIDTH  FIFO read data, valid the cycle after an accepted read
rinc  output  1  FIFO read request (combinational from registered state and rempty)
flush  input  1  single-cycle request to emit the partially filled word
m_valid  output  1  packed word valid
m_ready  input  1  downstream accept
m_data  output  WIDTH*RATIO  packed word; first word read in lane 0 (LSBs)
m_keep  output  RATIO  per-lane valid mask for m_data

Behaviour:
- Reset (async, rst_n low):
  - m_valid=0, m_data=0, m_keep=0; rinc=0 while in reset.
  - All internal state cleared: accumulator, lane_cnt=0, rd_pend=0, flush_pend=0, guard=0.
- Startup guard: rinc stays 0 in the first cycle after rst_n deasserts; guard sets at the first edge. Reason: the FIFO's rempty resets to 0 and is wrong for one cycle.
- Read issue: rinc = guard & !rempty & !rd_pend & !flush_pend & (lane_cnt < RATIO).
  - The !rd_pend term forbids back-to-back reads, because rempty lags one cycle. Peak rate is one FIFO word per 2 cycles.
- rd_pend <= rinc. When rd_pend=1: acc lane[lane_cnt] <= rdata; lane_cnt++.
- Transfer: acc moves to the output register when (lane_cnt==RATIO, or flush_pend & !rd_pend & lane_cnt>0) and (!m_valid | m_ready).
  - On transfer: m_data <= acc with unfilled lanes zero; m_keep <= low lane_cnt bits set; m_valid <= 1; lane_cnt <= 0; acc <= 0; flush_pend <= 0.
  - Accumulate and transfer never coincide: a transfer requires the accumulator full or no read pending.
- Output handshake: m_valid & m_ready with no transfer that cycle clears m_valid. m_data/m_keep hold stable while m_valid & !m_ready.
  - A transfer in the same cycle as acceptance is back-to-back, with no bubble.
- Flush:
  - flush=1 sets flush_pend. flush_pend blocks new reads.
  - With a read in flight, wait for it to land, then transfer.
  - If lane_cnt==0 and !rd_pend, flush_pend clears with no output.
  - flush while flush_pend is already set has no extra effect.
- Full-accumulator stall: lane_cnt==RATIO with m_valid & !m_ready means no reads and no transfer, and rinc=0. Back-pressure therefore reaches the FIFO, which fills and raises wfull.
- Reset mid-operation: the partial word and the output word are discarded; no output until new FIFO data arrives.
- Widths: lane_cnt is LW bits and saturates at RATIO (never wraps). m_keep for a full word is all ones.

Decomposition:
- Shared package: WIDTH/RATIO defaults, LW derivation function, lane-index helper (lane k = bits k*WIDTH +: WIDTH).
- No sub-module required; the single module contains the accumulator, output register, guard, and flush logic. Instantiated alongside sfifo in the top-level test harness.

Test Plan:
- Reset release with FIFO empty (FIFO rempty=0 for first cycle) -> rinc=0 in cycle 1; rinc stays 0 once rempty=1; m_valid=0.
- Write 0x11,0x22,0x33,0x44 into FIFO, m_ready=1 -> rinc pulses at most every other cycle; one beat m_data=0x44332211, m_keep=4'b1111; FIFO ends empty with no overread.
- Write 8 words 0x01..0x08, m_ready=0 for 20 cycles -> first word 0x04030201 held stable; acc fills 0x08070605; rinc then stays 0. Raising m_ready gives 2 consecutive beats, second 0x08070605.
- Write 0xAA,0xBB, then flush pulse while the second read is in flight -> m_data=0x0000BBAA, m_keep=4'b0011, one beat; no further rinc until flush is serviced.
- flush with accumulator empty and no read pending -> no m_valid; flush_pend clears next cycle.
- Assert rst_n low mid-pack (2 lanes filled, m_valid=1) -> outputs 0 immediately. After release, the guard cycle applies, and the next word packs from lane 0.

Source files
------------

// File: rtl/sfifo_rd_packer_pkg.sv
// Shared sizing defaults and lane helpers for the FIFO read-side packer.
// Lane k of a packed word occupies bits [k*WIDTH +: WIDTH].
package sfifo_rd_packer_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int RATIO_DEF = 4;

  // Lane counter must hold RATIO itself, so one bit more than the lane index.
  function automatic int lane_cnt_width(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sfifo_rd_packer_if.sv
// FIFO read port, flush request and packed output stream of the packer.
// master = packer side, slave = FIFO/downstream side.
interface sfifo_rd_packer_if #(
  parameter int WIDTH = sfifo_rd_packer_pkg::WIDTH_DEF,
  parameter int RATIO = sfifo_rd_packer_pkg::RATIO_DEF
);

  logic                     rempty;
  logic [WIDTH-1:0]         rdata;
  logic                     rinc;
  logic                     flush;
  logic                     m_valid;
  logic                     m_ready;
  logic [WIDTH*RATIO-1:0]   m_data;
  logic [RATIO-1:0]         m_keep;

  modport master (
    input  rempty, rdata, flush, m_ready,
    output rinc, m_valid, m_data, m_keep
  );

  modport slave (
    output rempty, rdata, flush, m_ready,
    input  rinc, m_valid, m_data, m_keep
  );

endinterface

// File: rtl/sfifo_rd_packer.sv
// Packs RATIO FIFO words into one wide word; one FIFO read per 2 cycles, output 1 cycle after last lane lands.
// Output stall with a full accumulator holds rinc low, so back-pressure reaches the FIFO.
module sfifo_rd_packer
  import sfifo_rd_packer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RATIO = RATIO_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  sfifo_rd_packer_if.master  bus
);

  localparam int              LW    = lane_cnt_width(RATIO);
  localparam int              DW    = WIDTH * RATIO;
  localparam logic [LW-1:0]   LANES = LW'(RATIO);

  logic             guard_q,      guard_d;
  logic             rd_pend_q,    rd_pend_d;
  logic             flush_pend_q, flush_pend_d;
  logic [LW-1:0]    lane_cnt_q,   lane_cnt_d;
  logic [DW-1:0]    acc_q,        acc_d;
  logic             m_valid_q,    m_valid_d;
  logic [DW-1:0]    m_data_q,     m_data_d;
  logic [RATIO-1:0] m_keep_q,     m_keep_d;

  logic lane_full;
  logic out_free;
  logic xfer;
  logic flush_drop;
  logic rinc;

  assign lane_full  = (lane_cnt_q == LANES);
  assign out_free   = !m_valid_q || bus.m_ready;
  // A flush only moves the word once any in-flight read has landed.
  assign xfer       = out_free &&
                      (lane_full || (flush_pend_q && !rd_pend_q && (lane_cnt_q != '0)));
  assign flush_drop = flush_pend_q && !rd_pend_q && (lane_cnt_q == '0);
  // rempty lags the read pointer by a cycle, hence at most every other cycle.
  assign rinc       = guard_q && !bus.rempty && !rd_pend_q && !flush_pend_q &&
                      (lane_cnt_q < LANES);

  always_comb begin
    guard_d      = 1'b1;
    rd_pend_d    = rinc;
    flush_pend_d = flush_pend_q || bus.flush;
    lane_cnt_d   = lane_cnt_q;
    acc_d        = acc_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;

    if (rd_pend_q) begin
      for (int k = 0; k < RATIO; k++) begin
        if (lane_cnt_q == LW'(k)) begin
          acc_d[lane_lo(k, WIDTH) +: WIDTH] = bus.rdata;
        end
      end
      lane_cnt_d = lane_cnt_q + LW'(1);
    end

    // Accumulate and transfer are mutually exclusive, so acc_q is final here.
    if (xfer) begin
      m_data_d     = acc_q;
      for (int k = 0; k < RATIO; k++) begin
        m_keep_d[k] = (LW'(k) < lane_cnt_q);
      end
      m_valid_d    = 1'b1;
      lane_cnt_d   = '0;
      acc_d        = '0;
      flush_pend_d = 1'b0;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_d    = 1'b0;
    end

    if (flush_drop) begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      lane_cnt_q   <= '0;
      acc_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
    end else begin
      guard_q      <= guard_d;
      rd_pend_q    <= rd_pend_d;
      flush_pend_q <= flush_pend_d;
      lane_cnt_q   <= lane_cnt_d;
      acc_q        <= acc_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
    end
  end

  assign bus.rinc    = rinc;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_keep  = m_keep_q;

  a_no_b2b_read: assert property (@(posedge clk) disable iff (!rst_n) rinc |=> !rinc);
  a_lane_sat:    assert property (@(posedge clk) disable iff (!rst_n) lane_cnt_q <= LANES);

endmodule

// File: tb/tb_sfifo_rd_packer.sv
// Bench for sfifo_rd_packer: queue-based FIFO environment, word-grouping reference model, scoreboard monitor.
module tb_sfifo_rd_packer;
  import sfifo_rd_packer_pkg::*;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int DW = W * R;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sfifo_rd_packer_if #(.WIDTH(W), .RATIO(R)) bus ();

  sfifo_rd_packer #(.WIDTH(W), .RATIO(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int beats = 0;

  logic [W-1:0]  fifo_q[$];
  logic [W-1:0]  wr_q[$];
  logic [W-1:0]  part_q[$];
  logic [DW-1:0] exp_dat_q[$];
  logic [R-1:0]  exp_keep_q[$];
  logic [DW-1:0] last_dat  = '0;
  logic [R-1:0]  last_keep = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Words popped since the last cut form the next packed word, first word in lane 0.
  function automatic void emit_part();
    logic [DW-1:0] d = '0;
    logic [R-1:0]  k = '0;
    for (int i = 0; i < part_q.size(); i++) begin
      d[i*W +: W] = part_q[i];
      k[i]        = 1'b1;
    end
    exp_dat_q.push_back(d);
    exp_keep_q.push_back(k);
    part_q.delete();
  endfunction

  // FIFO environment, reference model and output monitor.
  initial begin : env
    logic          rinc_s, flush_s, rinc_prev, hold_prev, empty_old;
    logic [DW-1:0] hold_dat;
    logic [R-1:0]  hold_keep;
    bus.rempty = 1'b0;
    bus.rdata  = '0;
    rinc_prev  = 1'b0;
    hold_prev  = 1'b0;
    hold_dat   = '0;
    hold_keep  = '0;
    forever begin
      @(negedge clk);
      rinc_s  = bus.rinc;
      flush_s = bus.flush;
      if (rst_n) begin
        if (rinc_s) begin
          check("rinc_overread", 64'(fifo_q.size() != 0), 64'd1);
          check("rinc_back_to_back", 64'(rinc_prev), 64'd0);
        end
        if (hold_prev) begin
          check("hold_valid", 64'(bus.m_valid), 64'd1);
          check("hold_data", 64'(bus.m_data), 64'(hold_dat));
          check("hold_keep", 64'(bus.m_keep), 64'(hold_keep));
        end
        if (bus.m_valid && bus.m_ready) begin
          beats++;
          last_dat  = bus.m_data;
          last_keep = bus.m_keep;
          if (exp_dat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got data %0h keep %0h, expected no beat (t=%0t)",
                     bus.m_data, bus.m_keep, $time);
          end else begin
            check("beat_data", 64'(bus.m_data), 64'(exp_dat_q.pop_front()));
            check("beat_keep", 64'(bus.m_keep), 64'(exp_keep_q.pop_front()));
          end
        end
        hold_prev = bus.m_valid && !bus.m_ready;
        hold_dat  = bus.m_data;
        hold_keep = bus.m_keep;
        rinc_prev = rinc_s;
      end else begin
        rinc_prev = 1'b0;
        hold_prev = 1'b0;
      end

      @(posedge clk);
      #1;
      if (!rst_n) begin
        fifo_q.delete();
        wr_q.delete();
        part_q.delete();
        exp_dat_q.delete();
        exp_keep_q.delete();
        bus.rempty = 1'b0;
        bus.rdata  = '0;
      end else begin
        empty_old = (fifo_q.size() == 0);
        if (rinc_s && fifo_q.size() != 0) begin
          bus.rdata = fifo_q.pop_front();
          pops++;
          part_q.push_back(bus.rdata);
          if (part_q.size() == R) emit_part();
        end
        if (flush_s && part_q.size() != 0) emit_part();
        while (wr_q.size() != 0) fifo_q.push_back(wr_q.pop_front());
        bus.rempty = empty_old;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic put(input logic [W-1:0] w);
    wr_q.push_back(w);
  endtask

  task automatic wait_pops(input int target, input int budget);
    int k = 0;
    while (pops < target && k < budget) begin
      step(1);
      k++;
    end
    check("wait_pops", 64'(pops), 64'(target));
  endtask

  function automatic logic idle();
    return fifo_q.size() == 0 && wr_q.size() == 0 && part_q.size() == 0 &&
           exp_dat_q.size() == 0 && !bus.m_valid;
  endfunction

  task automatic wait_drain(input int budget);
    int k = 0;
    while (!idle() && k < budget) begin
      step(1);
      k++;
    end
    check("drain", 64'(idle()), 64'd1);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
  endtask

  initial begin : stim
    int base;
    int n;
    bus.flush   = 1'b0;
    bus.m_ready = 1'b0;
    #1 rst_n = 1'b0;
    step(3);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_data", 64'(bus.m_data), 64'd0);
    check("rst_m_keep", 64'(bus.m_keep), 64'd0);
    check("rst_rinc", 64'(bus.rinc), 64'd0);

    // Release with the FIFO's rempty still (wrongly) low.
    rst_n = 1'b1;
    #1 check("guard_rinc", 64'(bus.rinc), 64'd0);
    step(1);
    check("empty_rinc", 64'(bus.rinc), 64'd0);
    check("empty_m_valid", 64'(bus.m_valid), 64'd0);
    step(2);
    check("empty_rinc2", 64'(bus.rinc), 64'd0);

    // One full word.
    bus.m_ready = 1'b1;
    base = beats;
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    wait_drain(80);
    check("full_beats", 64'(beats - base), 64'd1);
    check("full_data", 64'(last_dat), 64'h44332211);
    check("full_keep", 64'(last_keep), 64'hF);

    // Output stall with a second word accumulated behind it.
    bus.m_ready = 1'b0;
    base = beats;
    for (int i = 1; i <= 8; i++) put(8'(i));
    step(24);
    check("stall_valid", 64'(bus.m_valid), 64'd1);
    check("stall_data", 64'(bus.m_data), 64'h04030201);
    check("stall_keep", 64'(bus.m_keep), 64'hF);
    for (int i = 0; i < 3; i++) begin
      check("stall_rinc", 64'(bus.rinc), 64'd0);
      step(1);
    end
    bus.m_ready = 1'b1;
    step(1);
    check("b2b_valid", 64'(bus.m_valid), 64'd1);
    check("b2b_data", 64'(bus.m_data), 64'h08070605);
    step(1);
    check("b2b_done", 64'(bus.m_valid), 64'd0);
    check("b2b_beats", 64'(beats - base), 64'd2);
    wait_drain(40);

    // Flush while the second read is in flight.
    base = beats;
    n = pops;
    put(8'hAA); put(8'hBB);
    wait_pops(n + 2, 40);
    pulse_flush();
    check("flush_pend_rinc", 64'(bus.rinc), 64'd0);
    wait_drain(40);
    check("flush_beats", 64'(beats - base), 64'd1);
    check("flush_data", 64'(last_dat), 64'h0000BBAA);
    check("flush_keep", 64'(last_keep), 64'h3);

    // Flush with nothing accumulated: no beat, reads resume afterwards.
    step(2);
    base = beats;
    pulse_flush();
    for (int i = 0; i < 4; i++) begin
      check("empty_flush_valid", 64'(bus.m_valid), 64'd0);
      step(1);
    end
    check("empty_flush_beats", 64'(beats - base), 64'd0);
    n = pops;
    put(8'h5A);
    wait_pops(n + 1, 30);
    pulse_flush();
    wait_drain(40);
    check("single_data", 64'(last_dat), 64'h0000005A);
    check("single_keep", 64'(last_keep), 64'h1);

    // Reset mid-pack: one word held on the output, two lanes accumulated.
    bus.m_ready = 1'b0;
    n = pops;
    for (int i = 1; i <= 6; i++) put(8'(8'h60 + i));
    wait_pops(n + 6, 60);
    step(2);
    check("mid_valid", 64'(bus.m_valid), 64'd1);
    check("mid_data", 64'(bus.m_data), 64'h64636261);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.m_valid), 64'd0);
    check("mid_rst_data", 64'(bus.m_data), 64'd0);
    check("mid_rst_keep", 64'(bus.m_keep), 64'd0);
    check("mid_rst_rinc", 64'(bus.rinc), 64'd0);
    step(2);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    #1 check("mid_guard_rinc", 64'(bus.rinc), 64'd0);
    base = beats;
    put(8'h71); put(8'h72); put(8'h73); put(8'h74);
    wait_drain(80);
    check("post_rst_beats", 64'(beats - base), 64'd1);
    check("post_rst_data", 64'(last_dat), 64'h74737271);
    check("post_rst_keep", 64'(last_keep), 64'hF);

    // Random traffic, back-pressure and flushes against the grouping model.
    for (int c = 0; c < 800; c++) begin
      bus.m_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 4) put(8'($urandom));
      bus.flush = ($urandom_range(0, 39) == 0);
      step(1);
    end
    bus.flush   = 1'b0;
    bus.m_ready = 1'b1;
    begin
      int k = 0;
      while ((fifo_q.size() != 0 || wr_q.size() != 0) && k < 2000) begin
        step(1);
        k++;
      end
    end
    step(2);
    pulse_flush();
    wait_drain(200);
    check("final_exp_empty", 64'(exp_dat_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
